// File: rtl/fp_addsub_norm_if.sv
// rtl/fp_addsub_norm_if.sv - operand/result handshake bundle for fp_addsub_norm
interface fp_addsub_norm_if #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic              in_op_sub;
    logic              in_sign_a;
    logic              in_sign_b;
    logic [MANT_W-1:0] in_mant_a;
    logic [MANT_W-1:0] in_mant_b;
    logic [EXP_W-1:0]  in_exp;
    logic              in_guard;
    logic              in_round;
    logic              in_sticky;
    logic              in_bypass;

    logic              out_valid;
    logic              out_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_guard;
    logic              out_round;
    logic              out_sticky;
    logic              out_zero;
    logic              out_overflow;
    logic              out_subnormal;
    logic              out_bypass;

    modport master (
        output in_valid, in_op_sub, in_sign_a, in_sign_b, in_mant_a, in_mant_b,
               in_exp, in_guard, in_round, in_sticky, in_bypass, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_mant, out_guard,
               out_round, out_sticky, out_zero, out_overflow, out_subnormal, out_bypass
    );

    modport slave (
        input  in_valid, in_op_sub, in_sign_a, in_sign_b, in_mant_a, in_mant_b,
               in_exp, in_guard, in_round, in_sticky, in_bypass, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_mant, out_guard,
               out_round, out_sticky, out_zero, out_overflow, out_subnormal, out_bypass
    );
endinterface

// File: rtl/fp_addsub_norm.sv
// rtl/fp_addsub_norm.sv - aligned-mantissa add/sub with post-normalisation
// FP_FAST_NORM_EN selects one-cycle leading-zero normalisation instead of the serial shifter.
module fp_addsub_norm #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    fp_addsub_norm_if.slave bus
);
    localparam int XW = MANT_W + 3;

    typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;
    state_t state, stateNext;

    logic [XW-1:0]    resMant;
    logic [EXP_W-1:0] resExp;
    logic             resSign, resZero, resOvf, resSub, resBypass;

    logic             accept, effSub, effSignB, aBig;
    logic [XW-1:0]    extA, extB, diff, arithMant;
    logic [XW:0]      sum;
    logic [EXP_W:0]   expInc;
    logic [EXP_W-1:0] arithExp;
    logic             arithSign, arithOvf, arithZero;

    logic [XW-1:0]    normMant;
    logic [EXP_W-1:0] normExp;
    logic             normDone;

    assign accept = bus.in_valid && (state == IDLE);

    always_comb begin
        effSub   = bus.in_sign_a ^ bus.in_sign_b ^ bus.in_op_sub;
        effSignB = bus.in_sign_b ^ bus.in_op_sub;
        // Shifted-out bits belong to the smaller operand; ties give them to B.
        if (bus.in_mant_a < bus.in_mant_b) begin
            extA = {bus.in_mant_a, bus.in_guard, bus.in_round, bus.in_sticky};
            extB = {bus.in_mant_b, 3'b000};
        end else begin
            extA = {bus.in_mant_a, 3'b000};
            extB = {bus.in_mant_b, bus.in_guard, bus.in_round, bus.in_sticky};
        end
        aBig   = (extA >= extB);
        diff   = aBig ? (extA - extB) : (extB - extA);
        sum    = {1'b0, extA} + {1'b0, extB};
        expInc = {1'b0, bus.in_exp} + (EXP_W+1)'(1);

        arithSign = bus.in_sign_a;
        arithExp  = bus.in_exp;
        arithMant = sum[XW-1:0];
        arithOvf  = 1'b0;
        if (effSub) begin
            arithMant = diff;
            arithSign = aBig ? bus.in_sign_a : effSignB;
        end else if (sum[XW]) begin
            arithMant = {sum[XW:2], sum[1] | sum[0]};
            if (expInc[EXP_W] || (&expInc[EXP_W-1:0])) begin
                arithExp = '1;
                arithOvf = 1'b1;
            end else begin
                arithExp = expInc[EXP_W-1:0];
            end
        end
        arithZero = (arithMant == '0);
        if (arithZero) begin
            arithSign = 1'b0;
            arithExp  = '0;
            arithOvf  = 1'b0;
        end
    end

`ifdef FP_FAST_NORM_EN
    logic [EXP_W-1:0] lzc, maxShift, shAmt;

    always_comb begin
        lzc = EXP_W'(XW);
        for (int i = 0; i < XW; i++) begin
            if (resMant[i]) lzc = EXP_W'(XW - 1 - i);
        end
        // Never shift the exponent below 1; anything left unnormalised becomes subnormal.
        maxShift = (resExp > EXP_W'(1)) ? (resExp - EXP_W'(1)) : '0;
        shAmt    = (lzc < maxShift) ? lzc : maxShift;
        normMant = resMant << shAmt;
        normExp  = resExp - shAmt;
        normDone = 1'b1;
    end
`else
    logic canShift;

    always_comb begin
        canShift = !resMant[XW-1] && (resExp > EXP_W'(1));
        normMant = canShift ? (resMant << 1) : resMant;
        normExp  = canShift ? (resExp - EXP_W'(1)) : resExp;
        normDone = !canShift;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = bus.in_bypass ? HOLD : NORM;
            NORM:    if (normDone) stateNext = HOLD;
            HOLD:    if (bus.out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resMant   <= '0;
            resExp    <= '0;
            resSign   <= 1'b0;
            resZero   <= 1'b0;
            resOvf    <= 1'b0;
            resSub    <= 1'b0;
            resBypass <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resSub    <= 1'b0;
                        resBypass <= bus.in_bypass;
                        if (bus.in_bypass) begin
                            resMant <= '0;
                            resExp  <= '0;
                            resSign <= 1'b0;
                            resZero <= 1'b0;
                            resOvf  <= 1'b0;
                        end else begin
                            resMant <= arithMant;
                            resExp  <= arithExp;
                            resSign <= arithSign;
                            resZero <= arithZero;
                            resOvf  <= arithOvf;
                        end
                    end
                end
                NORM: begin
                    resMant <= normMant;
                    if (normDone && !normMant[XW-1] && !resZero) begin
                        resExp <= '0;
                        resSub <= 1'b1;
                    end else begin
                        resExp <= normExp;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready      = (state == IDLE);
    assign bus.out_valid     = (state == HOLD);
    assign bus.out_sign      = resSign;
    assign bus.out_exp       = resExp;
    assign bus.out_mant      = resMant[XW-1:3];
    assign bus.out_guard     = resMant[2];
    assign bus.out_round     = resMant[1];
    assign bus.out_sticky    = resMant[0];
    assign bus.out_zero      = resZero;
    assign bus.out_overflow  = resOvf;
    assign bus.out_subnormal = resSub;
    assign bus.out_bypass    = resBypass;
endmodule

// File: tb/tb_fp_addsub_norm.sv
// tb/tb_fp_addsub_norm.sv - directed vector bench for fp_addsub_norm
module tb_fp_addsub_norm;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    fp_addsub_norm_if #(.MANT_W(24), .EXP_W(8)) bus();
    fp_addsub_norm #(.MANT_W(24), .EXP_W(8)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

`ifdef FP_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        string       name;
        logic        opSub, signA, signB, bypass;
        logic [23:0] mantA, mantB;
        logic [7:0]  exp;
        logic [2:0]  grs;
        logic [39:0] want;
        int          shifts;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [39:0] pk(input logic s, input logic [7:0] e, input logic [23:0] m,
                                       input logic [2:0] grs, input logic z, input logic o,
                                       input logic sb, input logic b);
        return {s, e, m, grs, z, o, sb, b};
    endfunction

    function automatic vec_t mk(input string name, input logic opSub, input logic signA,
                                input logic signB, input logic [23:0] mantA,
                                input logic [23:0] mantB, input logic [7:0] exp,
                                input logic [2:0] grs, input logic bypass,
                                input logic [39:0] want, input int shifts);
        vec_t v;
        v.name = name; v.opSub = opSub; v.signA = signA; v.signB = signB;
        v.mantA = mantA; v.mantB = mantB; v.exp = exp; v.grs = grs; v.bypass = bypass;
        v.want = want; v.shifts = shifts;
        return v;
    endfunction

    function automatic logic [39:0] outs();
        return {bus.out_sign, bus.out_exp, bus.out_mant, bus.out_guard, bus.out_round,
                bus.out_sticky, bus.out_zero, bus.out_overflow, bus.out_subnormal, bus.out_bypass};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_op_sub = v.opSub;
        bus.in_sign_a = v.signA;
        bus.in_sign_b = v.signB;
        bus.in_mant_a = v.mantA;
        bus.in_mant_b = v.mantB;
        bus.in_exp    = v.exp;
        {bus.in_guard, bus.in_round, bus.in_sticky} = v.grs;
        bus.in_bypass = v.bypass;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
    endtask

    task automatic waitValid(output int lat);
        lat = 1;
        @(negedge clk);
        while (!bus.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat, expLat, seen;
        logic [39:0] snap;

        vecs[0] = mk("one_plus_one", 0, 0, 0, 24'h800000, 24'h800000, 8'd127, 3'b000, 0,
                     pk(0, 8'd128, 24'h800000, 3'b000, 0, 0, 0, 0), 0);
        vecs[1] = mk("onehalf_minus_one", 1, 0, 0, 24'hC00000, 24'h800000, 8'd127, 3'b000, 0,
                     pk(0, 8'd126, 24'h800000, 3'b000, 0, 0, 0, 0), 1);
        vecs[2] = mk("equal_sub_zero", 1, 0, 0, 24'hA00000, 24'hA00000, 8'd100, 3'b000, 0,
                     pk(0, 8'd0, 24'h000000, 3'b000, 1, 0, 0, 0), 0);
        vecs[3] = mk("overflow_add", 0, 0, 0, 24'hFFFFFF, 24'hFFFFFF, 8'd254, 3'b001, 0,
                     pk(0, 8'd255, 24'hFFFFFF, 3'b001, 0, 1, 0, 0), 0);
        vecs[4] = mk("bypass", 1, 1, 0, 24'h123456, 24'h654321, 8'd77, 3'b111, 1,
                     pk(0, 8'd0, 24'h000000, 3'b000, 0, 0, 0, 1), 0);
        vecs[5] = mk("neg_result_guard", 1, 0, 0, 24'h800000, 24'hC00000, 8'd127, 3'b100, 0,
                     pk(1, 8'd125, 24'hFFFFFE, 3'b000, 0, 0, 0, 0), 2);
        vecs[6] = mk("subnormal_add", 0, 1, 1, 24'h000100, 24'h000000, 8'd3, 3'b000, 0,
                     pk(1, 8'd0, 24'h000400, 3'b000, 0, 0, 1, 0), 2);
        vecs[7] = mk("mixed_sign_add", 0, 1, 0, 24'h900000, 24'h100000, 8'd50, 3'b000, 0,
                     pk(1, 8'd50, 24'h800000, 3'b000, 0, 0, 0, 0), 0);
        vecs[8] = mk("carry_round_sticky", 0, 0, 0, 24'hC00000, 24'h400000, 8'd10, 3'b010, 0,
                     pk(0, 8'd11, 24'h800000, 3'b001, 0, 0, 0, 0), 0);
        vecs[9] = mk("max_shift", 1, 0, 0, 24'h800000, 24'h800000, 8'd100, 3'b001, 0,
                     pk(1, 8'd74, 24'h800000, 3'b000, 0, 0, 0, 0), 26);

        reset_n = 1'b0;
        bus.in_valid = 0; bus.in_op_sub = 0; bus.in_sign_a = 0; bus.in_sign_b = 0;
        bus.in_mant_a = '0; bus.in_mant_b = '0; bus.in_exp = '0;
        bus.in_guard = 0; bus.in_round = 0; bus.in_sticky = 0; bus.in_bypass = 0;
        bus.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 64'({bus.out_valid, outs()}), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_in_ready", 64'({bus.in_ready, bus.out_valid}), 64'b10);

        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            waitValid(lat);
            expLat = vecs[i].bypass ? 1 : (FAST ? 2 : 2 + vecs[i].shifts);
            chk({vecs[i].name, "_latency"}, 64'(lat), 64'(expLat));
            chk({vecs[i].name, "_result"}, 64'(outs()), 64'(vecs[i].want));
            bus.out_ready = 1'b1;
            @(posedge clk);
            #1;
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk({vecs[i].name, "_idle"}, 64'({bus.in_ready, bus.out_valid}), 64'b10);
        end

        // Backpressure: result must hold while new operands are offered and ignored.
        drive(vecs[0]);
        waitValid(lat);
        snap = outs();
        for (int k = 0; k < 5; k++) begin
            bus.in_valid  = (k % 2 == 0);
            bus.in_mant_a = 24'($urandom);
            bus.in_bypass = 1'b1;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("hold_stable_%0d", k), 64'({bus.out_valid, bus.in_ready, outs()}),
                64'({1'b1, 1'b0, pk(0, 8'd128, 24'h800000, 3'b000, 0, 0, 0, 0)}));
        end
        chk("hold_snapshot", 64'(outs()), 64'(snap));
        bus.in_valid  = 1'b0;
        bus.in_bypass = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("hold_release_idle", 64'({bus.in_ready, bus.out_valid}), 64'b10);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("hold_no_accept", 64'(seen), 64'd0);

        // Reset in the middle of normalisation discards the operation.
        drive(mk("reset_norm", 1, 0, 0, 24'h000001, 24'h000000, 8'd30, 3'b000, 0, '0, 23));
        @(negedge clk);
        chk("midnorm_busy", 64'(bus.in_ready), 64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midnorm_reset_outputs", 64'({bus.out_valid, outs()}), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("midnorm_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("midnorm_no_valid", 64'(seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
